// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared definitions for the LED PWM array: the channel mode encoding, its
// field width, and the helper that folds a free-running count into a count
// relative to a channel's phase offset.
// ---------------------------------------------------------------------------
package led_pwm_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'b11;

    // Position of 'count' within the period measured from 'phase', wrapping
    // modulo 'period'. An out-of-range phase is treated as zero so software
    // cannot push a channel into a state where it never lines up.
    function automatic logic [31:0] rel_count(input logic [31:0] count,
                                              input logic [31:0] phase,
                                              input logic [31:0] period);
        logic [31:0] ph;
        ph = (phase >= period) ? 32'd0 : phase;
        if (count >= ph) begin
            rel_count = count - ph;
        end else begin
            rel_count = count + period - ph;
        end
    endfunction

endpackage

// File: rtl/led_pwm_array_if.sv
// ---------------------------------------------------------------------------
// led_pwm_array_if
// Configuration write bus for the LED PWM array.
//   Cfg_We    : single-cycle write strobe
//   Cfg_Ch    : target channel index
//   Cfg_Duty  : on-time in clock cycles
//   Cfg_Phase : start offset within the period
//   Cfg_Mode  : OFF / ON / PWM / BLINK
// master modport = board-control side, slave modport = the LED block.
// ---------------------------------------------------------------------------
interface led_pwm_array_if
    import led_pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 21
) ();

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              Cfg_We;
    logic [CH_W-1:0]   Cfg_Ch;
    logic [CNT_W-1:0]  Cfg_Duty;
    logic [CNT_W-1:0]  Cfg_Phase;
    logic [MODE_W-1:0] Cfg_Mode;

    modport master (
        output Cfg_We, Cfg_Ch, Cfg_Duty, Cfg_Phase, Cfg_Mode
    );

    modport slave (
        input Cfg_We, Cfg_Ch, Cfg_Duty, Cfg_Phase, Cfg_Mode
    );

endinterface

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel
// One LED channel. Keeps a shadow copy of the software configuration and an
// active copy that only changes on 'commit', so a period is never drawn with
// a half-updated setting. Produces one registered, active-high LED bit.
//   clk, rst     : clock, async active-high reset
//   en           : global enable; output forced off while low
//   commit       : copy shadow -> active on this edge
//   blink_state  : shared blink phase, gates BLINK mode
//   wr_en        : write strobe already decoded for this channel
//   wr_duty/wr_phase/wr_mode : values captured into the shadow
//   count        : shared period counter
//   led          : registered on-condition for this channel
// ---------------------------------------------------------------------------
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PERIOD = 2_000_000,
    parameter int CNT_W  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              commit,
    input  logic              blink_state,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_duty,
    input  logic [CNT_W-1:0]  wr_phase,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [CNT_W-1:0]  count,
    output logic              led
);

    logic [CNT_W-1:0]  shadow_duty_q, shadow_duty_d;
    logic [CNT_W-1:0]  shadow_phase_q, shadow_phase_d;
    logic [MODE_W-1:0] shadow_mode_q, shadow_mode_d;
    logic [CNT_W-1:0]  active_duty_q, active_duty_d;
    logic [CNT_W-1:0]  active_phase_q, active_phase_d;
    logic [MODE_W-1:0] active_mode_q, active_mode_d;
    logic              led_q, led_d;

    logic [31:0]       rel;
    logic              pwm_on;
    logic              on_now;

    // The commit copies the shadow value seen before this edge, so a write
    // landing on a commit edge waits for the following commit.
    always_comb begin
        shadow_duty_d  = shadow_duty_q;
        shadow_phase_d = shadow_phase_q;
        shadow_mode_d  = shadow_mode_q;
        active_duty_d  = active_duty_q;
        active_phase_d = active_phase_q;
        active_mode_d  = active_mode_q;
        if (wr_en) begin
            shadow_duty_d  = wr_duty;
            shadow_phase_d = wr_phase;
            shadow_mode_d  = wr_mode;
        end
        if (commit) begin
            active_duty_d  = shadow_duty_q;
            active_phase_d = shadow_phase_q;
            active_mode_d  = shadow_mode_q;
        end
    end

    // Duty is compared as a full 32-bit value, so a duty at or beyond the
    // period naturally yields "always on" and zero yields "never on".
    always_comb begin
        rel    = rel_count(32'(count), 32'(active_phase_q), 32'(PERIOD));
        pwm_on = (rel < 32'(active_duty_q));
        case (active_mode_q)
            MODE_OFF:   on_now = 1'b0;
            MODE_ON:    on_now = 1'b1;
            MODE_PWM:   on_now = pwm_on;
            MODE_BLINK: on_now = pwm_on & blink_state;
            default:    on_now = 1'b0;
        endcase
        led_d = en & on_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_duty_q  <= '0;
            shadow_phase_q <= '0;
            shadow_mode_q  <= MODE_OFF;
            active_duty_q  <= '0;
            active_phase_q <= '0;
            active_mode_q  <= MODE_OFF;
            led_q          <= 1'b0;
        end else begin
            shadow_duty_q  <= shadow_duty_d;
            shadow_phase_q <= shadow_phase_d;
            shadow_mode_q  <= shadow_mode_d;
            active_duty_q  <= active_duty_d;
            active_phase_q <= active_phase_d;
            active_mode_q  <= active_mode_d;
            led_q          <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_array.sv
// ---------------------------------------------------------------------------
// led_pwm_array
// N-channel LED PWM / blink generator. One shared period counter drives all
// channels; per-channel configuration is written through the cfg bus and
// takes effect only at a period boundary (or immediately while disabled).
//   CLK         : system clock
//   RST         : async active-high reset
//   En          : global enable
//   cfg         : configuration write bus (slave side)
//   LED_Out     : registered LED drive, inverted when ACTIVE_LOW != 0
//   Period_Tick : one-cycle pulse in the cycle after each wrap edge
// ---------------------------------------------------------------------------
module led_pwm_array
    import led_pwm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PERIOD     = 2_000_000,
    parameter int CNT_W      = $clog2(PERIOD),
    parameter int BLINK_DIV  = 5,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    led_pwm_array_if.slave   cfg,
    output logic [N_CH-1:0]  LED_Out,
    output logic             Period_Tick
);

    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               tick_q, tick_d;
    logic               wrap;
    logic               commit;
    logic [N_CH-1:0]    led_raw;

    // Shared period counter. It is held at zero while disabled so every
    // enable starts a fresh, aligned period.
    always_comb begin
        wrap    = En && (count_q == CNT_W'(PERIOD - 1));
        commit  = wrap || !En;
        count_d = count_q + CNT_W'(1);
        if (!En || wrap) begin
            count_d = '0;
        end
        tick_d = wrap;
    end

    // Blink divider counts wraps and flips the blink phase every BLINK_DIV
    // of them, so the first BLINK_DIV periods after enable are dark.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!En) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
        end
    end

    // Channel index decode: an index with no matching channel simply
    // matches nothing, which is how out-of-range writes get dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

        led_pwm_channel #(
            .PERIOD (PERIOD),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk         (CLK),
            .rst         (RST),
            .en          (En),
            .commit      (commit),
            .blink_state (blink_q),
            .wr_en       (cfg.Cfg_We && (cfg.Cfg_Ch == CH_IDX)),
            .wr_duty     (cfg.Cfg_Duty),
            .wr_phase    (cfg.Cfg_Phase),
            .wr_mode     (cfg.Cfg_Mode),
            .count       (count_q),
            .led         (led_raw[i])
        );
    end

    // Polarity is applied only at the pins; a reset register value of zero
    // therefore shows up as the inactive level for either polarity.
    if (ACTIVE_LOW != 0) begin : g_low
        assign LED_Out = ~led_raw;
    end else begin : g_high
        assign LED_Out = led_raw;
    end

    assign Period_Tick = tick_q;

endmodule

// File: tb/tb_led_pwm_array.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_array
// Drives two copies of the LED array (active-high and active-low pins) from
// the same configuration bus and compares both against a reference model
// that reasons in periods and wrap counts rather than registers.
// ---------------------------------------------------------------------------
module tb_led_pwm_array;
    import led_pwm_pkg::*;

    localparam int N_CH      = 4;
    localparam int PERIOD    = 10;
    localparam int BLINK_DIV = 2;
    localparam int CNT_W     = $clog2(PERIOD);

    logic            CLK = 1'b0;
    logic            RST;
    logic            En;
    logic [N_CH-1:0] led_hi, led_lo;
    logic            tick_hi, tick_lo;

    led_pwm_array_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_bus ();

    led_pwm_array #(
        .N_CH(N_CH), .PERIOD(PERIOD), .CNT_W(CNT_W),
        .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(0)
    ) dut_hi (
        .CLK(CLK), .RST(RST), .En(En), .cfg(cfg_bus.slave),
        .LED_Out(led_hi), .Period_Tick(tick_hi)
    );

    led_pwm_array #(
        .N_CH(N_CH), .PERIOD(PERIOD), .CNT_W(CNT_W),
        .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1)
    ) dut_lo (
        .CLK(CLK), .RST(RST), .En(En), .cfg(cfg_bus.slave),
        .LED_Out(led_lo), .Period_Tick(tick_lo)
    );

    always #5 CLK = ~CLK;

    // Reference model state: position in the period, wraps seen since
    // enable, and the shadow/active settings per channel.
    int m_count;
    int m_wraps;
    int sh_duty[N_CH], sh_phase[N_CH], sh_mode[N_CH];
    int ac_duty[N_CH], ac_phase[N_CH], ac_mode[N_CH];
    logic [N_CH-1:0] exp_led;
    logic            exp_tick;

    int    checks;
    int    failures;
    string phase_tag;

    // Channel on-condition from the active settings, using modular
    // arithmetic on the period and the wrap count for the blink phase.
    function automatic bit chOn(int ch);
        int  ph;
        int  rel;
        bit  pwm;
        bit  blink;
        ph    = (ac_phase[ch] >= PERIOD) ? 0 : ac_phase[ch];
        rel   = (m_count - ph + PERIOD) % PERIOD;
        pwm   = (rel < ac_duty[ch]);
        blink = ((m_wraps / BLINK_DIV) % 2) == 1;
        case (ac_mode[ch])
            1:       return 1'b1;
            2:       return pwm;
            3:       return pwm && blink;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        m_count  = 0;
        m_wraps  = 0;
        exp_led  = '0;
        exp_tick = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            sh_duty[i] = 0; sh_phase[i] = 0; sh_mode[i] = 0;
            ac_duty[i] = 0; ac_phase[i] = 0; ac_mode[i] = 0;
        end
    endtask

    // One rising edge of the model, using the inputs that are stable at
    // that edge (they only change around the falling edge).
    task automatic modelEdge();
        logic [N_CH-1:0] nxt_led;
        bit              wrap;
        if (RST) begin
            modelReset();
            return;
        end
        wrap = En && (m_count == PERIOD - 1);
        for (int i = 0; i < N_CH; i++) begin
            nxt_led[i] = En && chOn(i);
        end
        if (!En || wrap) begin
            for (int i = 0; i < N_CH; i++) begin
                ac_duty[i]  = sh_duty[i];
                ac_phase[i] = sh_phase[i];
                ac_mode[i]  = sh_mode[i];
            end
        end
        if (cfg_bus.Cfg_We && int'(cfg_bus.Cfg_Ch) < N_CH) begin
            sh_duty[cfg_bus.Cfg_Ch]  = int'(cfg_bus.Cfg_Duty);
            sh_phase[cfg_bus.Cfg_Ch] = int'(cfg_bus.Cfg_Phase);
            sh_mode[cfg_bus.Cfg_Ch]  = int'(cfg_bus.Cfg_Mode);
        end
        m_count  = !En ? 0 : (m_count + 1) % PERIOD;
        m_wraps  = !En ? 0 : (wrap ? m_wraps + 1 : m_wraps);
        exp_led  = nxt_led;
        exp_tick = wrap;
    endtask

    // Compare both DUT copies against the model.
    task automatic checkOutput(string tag);
        checks++;
        assert (led_hi === exp_led) else begin
            failures++;
            $error("[TB] FAIL %s led_hi observed=%b expected=%b", tag, led_hi, exp_led);
        end
        checks++;
        assert (led_lo === ~exp_led) else begin
            failures++;
            $error("[TB] FAIL %s led_lo observed=%b expected=%b", tag, led_lo, ~exp_led);
        end
        checks++;
        assert (tick_hi === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s tick_hi observed=%b expected=%b", tag, tick_hi, exp_tick);
        end
        checks++;
        assert (tick_lo === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s tick_lo observed=%b expected=%b", tag, tick_lo, exp_tick);
        end
    endtask

    // Advance a number of clock cycles, checking every cycle at the
    // falling edge.
    task automatic applyStimulus(int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            modelEdge();
            @(negedge CLK);
            checkOutput(phase_tag);
        end
    endtask

    task automatic writeCfg(int ch, int duty, int phase, int mode);
        cfg_bus.Cfg_We    = 1'b1;
        cfg_bus.Cfg_Ch    = ch[1:0];
        cfg_bus.Cfg_Duty  = duty[CNT_W-1:0];
        cfg_bus.Cfg_Phase = phase[CNT_W-1:0];
        cfg_bus.Cfg_Mode  = mode[1:0];
        applyStimulus(1);
        cfg_bus.Cfg_We    = 1'b0;
    endtask

    // Step until the model sits at a given count, with a bounded budget.
    task automatic waitCount(int c);
        int n;
        n = 0;
        while (m_count != c && n < 2 * PERIOD) begin
            applyStimulus(1);
            n++;
        end
        checks++;
        assert (m_count == c) else begin
            failures++;
            $error("[TB] FAIL waitCount observed=%0d expected=%0d", m_count, c);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelReset();
        RST               = 1'b1;
        En                = 1'b0;
        cfg_bus.Cfg_We    = 1'b0;
        cfg_bus.Cfg_Ch    = '0;
        cfg_bus.Cfg_Duty  = '0;
        cfg_bus.Cfg_Phase = '0;
        cfg_bus.Cfg_Mode  = MODE_OFF;

        // Reset and startup with no configuration: dark LEDs, regular ticks.
        phase_tag = "reset";
        applyStimulus(2);
        RST = 1'b0;
        applyStimulus(1);
        En = 1'b1;
        phase_tag = "startup";
        applyStimulus(25);

        // PWM with and without phase offset.
        phase_tag = "pwm_phase";
        writeCfg(0, 3, 0, 2);
        writeCfg(1, 3, 8, 2);
        applyStimulus(30);

        // Duty extremes and an out-of-range phase.
        phase_tag = "duty_bounds";
        writeCfg(2, 0, 0, 2);
        applyStimulus(12);
        writeCfg(2, 10, 0, 2);
        applyStimulus(12);
        writeCfg(2, 15, 0, 2);
        applyStimulus(12);
        writeCfg(3, 4, 12, 2);
        applyStimulus(22);

        // Mid-period change followed by a write exactly on the wrap edge.
        phase_tag = "commit";
        waitCount(4);
        writeCfg(0, 7, 0, 2);
        waitCount(9);
        writeCfg(0, 2, 0, 2);
        applyStimulus(30);

        // Blink from a fresh enable, then a disable/enable restart.
        phase_tag = "blink";
        En = 1'b0;
        applyStimulus(3);
        writeCfg(0, 5, 0, 3);
        En = 1'b1;
        applyStimulus(70);
        En = 1'b0;
        applyStimulus(3);
        En = 1'b1;
        applyStimulus(50);

        // Randomised writes and occasional enable toggles.
        phase_tag = "random";
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                writeCfg(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            end else begin
                if ($urandom_range(0, 39) == 0) begin
                    En = ~En;
                end
                applyStimulus(1);
            end
        end

        // Async reset while channel 0 is lit, observed before any clock edge.
        phase_tag = "async_prep";
        En = 1'b1;
        writeCfg(0, 15, 0, 1);
        applyStimulus(PERIOD + 2);
        checks++;
        assert (led_lo[0] === 1'b0) else begin
            failures++;
            $error("[TB] FAIL lit_before_reset observed=%b expected=%b", led_lo[0], 1'b0);
        end
        RST = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        phase_tag = "in_reset";
        applyStimulus(3);
        RST = 1'b0;
        phase_tag = "after_reset";
        applyStimulus(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
